// File: rtl/uart_rx_byte.sv
// UART receiver: 2-FF synchronised line, mid-bit sampling, 8 data bits LSB-first,
// one-byte valid/ready holding register. Optional even parity with `UART_RX_PARITY_EN.
module uart_rx_byte #(
  parameter int CLK_FREQ  = 125000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_pin_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam logic [14:0] BIT_LAST  = 15'(CLKS_PER_BIT - 1);
  localparam logic [14:0] HALF_LAST = 15'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync2_q;
  logic [14:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  rx_data_q;
  logic        rx_valid_q;
  logic        frame_err_q;
  logic        overrun_q;
  logic        deliver_s;
  logic        ferr_s;
  logic        rxs;

`ifdef UART_RX_PARITY_EN
  logic        par_bad_q, par_bad_d;
  logic        perr_s;
  logic        parity_err_q;

  function automatic logic even_parity_ok(input logic [7:0] d, input logic p);
    return ~(^d ^ p);
  endfunction
`endif

  assign rxs = sync2_q;

  // Two-flop synchroniser for the asynchronous line, idling high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_pin_in;
      sync2_q <= sync1_q;
    end
  end

  // Receive FSM state, baud counter, bit index and shift register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 15'd0;
      idx_q   <= 3'd0;
      shreg_q <= 8'h00;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  // Next-state logic; sample points are mid-start, then one bit period apart.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    deliver_s = 1'b0;
    ferr_s    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_s    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = 15'd0;
        if (!rxs) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = 15'd0;
          idx_d = 3'd0;
          if (rxs) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
          end
        end else begin
          cnt_d = cnt_q + 15'd1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = 15'd0;
          shreg_d[idx_q] = rxs;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 15'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = 15'd0;
          par_bad_d = ~even_parity_ok(shreg_q, rxs);
          perr_s    = ~even_parity_ok(shreg_q, rxs);
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + 15'd1;
        end
      end
`endif
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = 15'd0;
          if (rxs) begin
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            deliver_s = ~par_bad_q;
`else
            deliver_s = 1'b1;
`endif
          end else begin
            ferr_s  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q + 15'd1;
        end
      end
      BREAK: begin
        cnt_d = 15'd0;
        if (rxs) begin
          state_d = IDLE;
        end else begin
          state_d = BREAK;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 15'd0;
      end
    endcase
  end

  // Holding register: a new byte replaces the old one only if it is being consumed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= ferr_s;
      overrun_q   <= deliver_s & rx_valid_q & ~rx_ready;
      if (deliver_s && (!rx_valid_q || rx_ready)) begin
        rx_data_q  <= shreg_q;
        rx_valid_q <= 1'b1;
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity error pulse register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= perr_s;
    end
  end
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte: directed frames plus random bytes against a
// queue-based model. Uses a 16-clock bit period to keep the run short.
module tb_uart_rx_byte;

  localparam int CLK_FREQ  = 1600000;
  localparam int BAUD_RATE = 100000;
  localparam int BIT       = CLK_FREQ / BAUD_RATE;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_pin_in = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] acc_q[$];
  int vcyc_n = 0;
  int ferr_n = 0;
  int ovr_n  = 0;
  int perr_n = 0;

  uart_rx_byte #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk(clk), .rst(rst), .rx_pin_in(rx_pin_in),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  // Observer on the falling edge: records handshakes and error pulses.
  always @(negedge clk) begin
    if (rst) begin
      if (rx_valid && rx_ready) acc_q.push_back(rx_data);
      if (rx_valid)   vcyc_n = vcyc_n + 1;
      if (frame_err)  ferr_n = ferr_n + 1;
      if (overrun)    ovr_n  = ovr_n + 1;
      if (parity_err) perr_n = perr_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drive_bit(input logic b);
    rx_pin_in = b;
    tick(BIT);
  endtask

  // Frame: start, 8 data LSB-first, [even parity, optionally flipped], stop.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic flip_par);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ flip_par);
`else
    if (flip_par) $display("note: parity flip ignored in 8N1 build");
`endif
    drive_bit(stop_b);
    rx_pin_in = 1'b1;
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] d);
    if (acc_q.size() == 0) begin
      check({tag, "_count"}, 32'd0, 32'd1);
    end else begin
      check(tag, {24'd0, acc_q.pop_front()}, {24'd0, d});
    end
  endtask

  logic [7:0] model_q[$];
  int v0, f0, o0, p0, a0;

  task automatic snap();
    v0 = vcyc_n; f0 = ferr_n; o0 = ovr_n; p0 = perr_n; a0 = acc_q.size();
  endtask

  initial begin
    // Reset state.
    tick(3);
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_data", {24'd0, rx_data}, 32'd0);
    check("rst_pulses", {29'd0, frame_err, overrun, parity_err}, 32'd0);
    rst = 1'b1;
    tick(BIT);

    // 1: single byte with consumer ready; valid lasts exactly one cycle.
    snap();
    send_frame(8'h30, 1'b1, 1'b0);
    tick(BIT);
    check("t1_vcycles", vcyc_n - v0, 32'd1);
    check("t1_errs", (ferr_n - f0) + (ovr_n - o0) + (perr_n - p0), 32'd0);
    expect_byte("t1_data", 8'h30);

    // 2: consumer stalled, second byte overruns and is dropped.
    rx_ready = 1'b0;
    snap();
    send_frame(8'h52, 1'b1, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b0);
    tick(BIT);
    check("t2_valid", {31'd0, rx_valid}, 32'd1);
    check("t2_data", {24'd0, rx_data}, 32'h52);
    check("t2_overrun", ovr_n - o0, 32'd1);
    rx_ready = 1'b1;
    tick(1);
    check("t2_drop", {31'd0, rx_valid}, 32'd0);
    expect_byte("t2_acc", 8'h52);
    check("t2_extra", acc_q.size(), 32'd0);

    // 3: short low glitch on the idle line.
    snap();
    rx_pin_in = 1'b0;
    tick(3);
    rx_pin_in = 1'b1;
    tick(3 * BIT);
    check("t3_novalid", vcyc_n - v0, 32'd0);
    check("t3_noferr", ferr_n - f0, 32'd0);

    // 4: bad stop bit, line held low, then a good byte.
    snap();
    send_frame(8'h30, 1'b0, 1'b0);
    rx_pin_in = 1'b0;
    tick(2 * BIT);
    rx_pin_in = 1'b1;
    tick(BIT);
    check("t4_ferr", ferr_n - f0, 32'd1);
    check("t4_novalid", vcyc_n - v0, 32'd0);
    send_frame(8'h31, 1'b1, 1'b0);
    tick(BIT);
    expect_byte("t4_next", 8'h31);

    // 5: reset in the middle of data bit 4.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'h55 >> i));
    rx_pin_in = 1'b0;
    tick(BIT / 2);
    rst = 1'b0;
    #1;
    check("t5_data", {24'd0, rx_data}, 32'd0);
    check("t5_outs", {28'd0, rx_valid, frame_err, overrun, parity_err}, 32'd0);
    tick(4);
    rx_pin_in = 1'b1;
    rst = 1'b1;
    tick(BIT);
    snap();
    send_frame(8'h7E, 1'b1, 1'b0);
    tick(BIT);
    expect_byte("t5_after", 8'h7E);
    check("t5_errs", (ferr_n - f0) + (ovr_n - o0), 32'd0);

`ifdef UART_RX_PARITY_EN
    // 6: parity good then parity bad.
    snap();
    send_frame(8'h30, 1'b1, 1'b0);
    tick(BIT);
    expect_byte("t6_good", 8'h30);
    check("t6_noperr", perr_n - p0, 32'd0);
    snap();
    send_frame(8'h30, 1'b1, 1'b1);
    tick(BIT);
    check("t6_perr", perr_n - p0, 32'd1);
    check("t6_novalid", vcyc_n - v0, 32'd0);
`endif

    // Random bytes, random inter-frame gaps, some with bad stop bits.
    snap();
    for (int k = 0; k < 24; k++) begin
      logic [7:0] d;
      logic good;
      d = 8'($urandom);
      good = ($urandom_range(0, 5) != 0);
      send_frame(d, good, 1'b0);
      if (good) begin
        model_q.push_back(d);
      end else begin
        tick(BIT);
      end
      tick($urandom_range(0, 2 * BIT));
    end
    tick(BIT);
    check("rnd_count", acc_q.size(), model_q.size());
    while (model_q.size() > 0) begin
      expect_byte("rnd_data", model_q.pop_front());
    end
    check("rnd_overrun", ovr_n - o0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
